cache_line_burst_adapter: RTL and testbench
===========================================

Name: cache_line_burst_adapter

Overview:
- Parametrised line-to-burst converter between the cache miss path (dfp side, one full line per request) and the burst memory bus (bmem side, BUS_WIDTH per beat).
- Replaces the fixed 256/64 adapter with an explicit FSM, latched requests, a per-line beat counter that restarts every transaction, and registered, single-cycle line responses.
- Exactly one outstanding transaction at a time.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BUS_WIDTH, 64, memory bus beat width in bits.
- ADDR_WIDTH, 32, address width.
- BEATS is derived as LINE_WIDTH/BUS_WIDTH. It must be a power of 2 and at least 2. Elaboration fails otherwise.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- dfp_addr  in  ADDR_WIDTH  line-aligned request address
- dfp_read  in  1  line read request, held until response
- dfp_write  in  1  line write request, held until response
- dfp_wdata  in  LINE_WIDTH  write line; beat 0 = bits [BUS_WIDTH-1:0]
- dfp_rdata  out  LINE_WIDTH  assembled read line, valid with dfp_r_resp
- dfp_raddr  out  ADDR_WIDTH  address tag returned by memory for the read
- dfp_r_resp  out  1  one-cycle read-done pulse
- dfp_w_resp  out  1  one-cycle write-done pulse
- bmem_addr  out  ADDR_WIDTH  burst address
- bmem_read  out  1  read burst request
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BUS_WIDTH  write beat data
- bmem_ready  in  1  memory accepts the request/beat this cycle
- bmem_rdata  in  BUS_WIDTH  read beat data
- bmem_raddr  in  ADDR_WIDTH  address tag of the returning read burst
- bmem_resp  in  1  read beat valid

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE and beat counter to 0.
  - All outputs go to 0, including dfp_rdata and dfp_raddr.
  - Any partial transaction is discarded. No resp pulse is generated for it after release.
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.
- IDLE:
  - dfp_read=1 latches dfp_addr and goes to RD_REQ.
  - Otherwise dfp_write=1 latches dfp_addr and dfp_wdata and goes to WR_DATA.
  - If both are high, read wins; the write stays pending and is served after the read's response.
- RD_REQ:
  - bmem_read=1 and bmem_addr=latched address.
  - Stays until bmem_ready=1, then goes to RD_DATA with count=0.
  - bmem_read is never high for more than one accepted cycle per line.
- RD_DATA:
  - Each cycle with bmem_resp=1 stores bmem_rdata into line slot [count].
  - On count=0, dfp_raddr is captured from bmem_raddr.
  - count then increments. Gaps between beats (bmem_resp=0) are tolerated.
  - The last beat (count=BEATS-1) goes to RESP.
- WR_DATA:
  - bmem_write=1, bmem_addr=latched address, bmem_wdata=latched slot [count].
  - count increments only on cycles with bmem_ready=1. bmem_wdata holds while ready is low.
  - The accepted last beat goes to RESP.
- RESP:
  - Exactly one of dfp_r_resp or dfp_w_resp is high for one cycle, then the FSM returns to IDLE.
  - dfp_rdata and dfp_raddr stay stable from RESP until the next read's RESP.
  - The requester must drop its request in the RESP cycle. A request still high in IDLE starts a new transaction.
- Latency:
  - Read: dfp_r_resp is asserted 1 cycle after the cycle carrying the last beat.
  - Write: dfp_w_resp is asserted 1 cycle after the accepted last beat.
  - Minimum write latency is BEATS+1 cycles from IDLE acceptance.
- bmem_resp outside RD_DATA is ignored.
- The counter is $clog2(BEATS) bits. Wrap-around is never used; it is cleared on every entry to RD_DATA or WR_DATA.
- bmem_read and bmem_write are never high simultaneously.

Test Plan:
- Default params, read 0x0000_1000, ready on first cycle, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> one dfp_r_resp pulse with dfp_rdata={0x44..,0x33..,0x22..,0x11..} and dfp_raddr=0x1000.
- Read with 2-cycle gaps between beats and ready held low for 3 cycles -> bmem_read high for 4 cycles total, correct line, a single resp pulse.
- Write of line {D3,D2,D1,D0} with ready toggling 1,0,1,1,0,1 -> bmem_wdata sequence D0,D1,D1,D2,D3,D3, then dfp_w_resp 1 cycle after the 4th accepted beat.
- dfp_read and dfp_write both high in IDLE -> read completes first, then the write, each with exactly one pulse.
- rst low after the 2nd read beat, then a fresh read -> no stale pulse; the new line contains only new beats.
- LINE_WIDTH=512, BUS_WIDTH=128 -> 4 beats, correct slot order; LINE_WIDTH=512, BUS_WIDTH=64 -> 8-beat burst, correct.

Source files
------------

// File: rtl/cache_line_burst_adapter.sv
// Converts one cache-line request into a burst of BUS_WIDTH beats on the memory bus.
// Only one transaction is outstanding at a time; line responses are single-cycle pulses.
module cache_line_burst_adapter #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic [ADDR_WIDTH-1:0] dfp_raddr,
  output logic                  dfp_r_resp,
  output logic                  dfp_w_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BUS_WIDTH-1:0]  bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [BUS_WIDTH-1:0]  bmem_rdata,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic                  bmem_resp
);

  localparam int unsigned BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if ((BEATS < 2) || ((BEATS & (BEATS - 1)) != 0) || (BEATS * BUS_WIDTH != LINE_WIDTH))
  begin : g_bad_params
    $error("LINE_WIDTH/BUS_WIDTH must be an exact power of two of at least 2");
  end

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, RESP} state_t;

  state_t                          state, state_next;
  logic [CW-1:0]                   cnt;
  logic                            op_rd;
  logic [ADDR_WIDTH-1:0]           addr_q, raddr_stage, raddr_q;
  logic [BEATS-1:0][BUS_WIDTH-1:0] wline, rbuf, rbuf_next, rline_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dfp_read)                      state_next = RD_REQ;
               else if (dfp_write)                state_next = WR_DATA;
      RD_REQ:  if (bmem_ready)                    state_next = RD_DATA;
      RD_DATA: if (bmem_resp && (cnt == LAST))    state_next = RESP;
      WR_DATA: if (bmem_ready && (cnt == LAST))   state_next = RESP;
      RESP:                                       state_next = IDLE;
      default:                                    state_next = IDLE;
    endcase
  end

  // Beats accumulate in rbuf; the visible line only changes when the last beat lands.
  always_comb begin
    rbuf_next      = rbuf;
    rbuf_next[cnt] = bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      op_rd       <= 1'b0;
      addr_q      <= '0;
      raddr_stage <= '0;
      raddr_q     <= '0;
      wline       <= '0;
      rbuf        <= '0;
      rline_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dfp_read) begin
            addr_q <= dfp_addr;
            op_rd  <= 1'b1;
          end else if (dfp_write) begin
            addr_q <= dfp_addr;
            wline  <= dfp_wdata;
            op_rd  <= 1'b0;
          end
        end
        RD_REQ: cnt <= '0;
        RD_DATA: begin
          if (bmem_resp) begin
            rbuf <= rbuf_next;
            cnt  <= cnt + 1'b1;
            if (cnt == '0) raddr_stage <= bmem_raddr;
            if (cnt == LAST) begin
              rline_q <= rbuf_next;
              raddr_q <= raddr_stage;
            end
          end
        end
        WR_DATA: if (bmem_ready) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign dfp_rdata  = rline_q;
  assign dfp_raddr  = raddr_q;
  assign dfp_r_resp = (state == RESP) && op_rd;
  assign dfp_w_resp = (state == RESP) && !op_rd;
  assign bmem_read  = (state == RD_REQ);
  assign bmem_write = (state == WR_DATA);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? wline[cnt] : '0;

endmodule

// File: tb/tb_cache_line_burst_adapter.sv
// Randomised bench for cache_line_burst_adapter: the bench acts as line memory and requester
// for three geometries and checks lines, pulses and beat ordering against a line-level model.
module tb_cache_line_burst_adapter;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int LW = (g == 0) ? 256 : 512;
    localparam int BW = (g == 1) ? 128 : 64;
    localparam int NB = LW / BW;

    logic          rst;
    logic [AW-1:0] dfp_addr, dfp_raddr, bmem_addr, bmem_raddr;
    logic          dfp_read, dfp_write, dfp_r_resp, dfp_w_resp;
    logic [LW-1:0] dfp_wdata, dfp_rdata;
    logic          bmem_read, bmem_write, bmem_ready, bmem_resp;
    logic [BW-1:0] bmem_wdata, bmem_rdata;
    logic          done = 1'b0;
    int            n_rresp, n_wresp, n_bread, n_both;
    logic [LW-1:0] mem [logic [AW-1:0]];

    cache_line_burst_adapter #(.LINE_WIDTH(LW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
      .dfp_rdata(dfp_rdata), .dfp_raddr(dfp_raddr), .dfp_r_resp(dfp_r_resp), .dfp_w_resp(dfp_w_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
      .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata), .bmem_raddr(bmem_raddr), .bmem_resp(bmem_resp)
    );

    task automatic tick();
      @(negedge clk);
      n_rresp += int'(dfp_r_resp);
      n_wresp += int'(dfp_w_resp);
      n_bread += int'(bmem_read);
      if (bmem_read && bmem_write) n_both++;
    endtask

    function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
      return AW'($urandom_range(15, 0) * (LW / 8) + 32'h0001_0000);
    endfunction

    function automatic logic [BW-1:0] junk();
      return BW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    function automatic string tg(input string s);
      return $sformatf("c%0d_%s", g, s);
    endfunction

    task automatic check_outs_zero(input string tag);
      check(tg({tag, "_ctl"}), 512'({dfp_r_resp, dfp_w_resp, bmem_read, bmem_write}), 512'(0));
      check(tg({tag, "_bus"}), 512'({bmem_addr, bmem_wdata, dfp_raddr}), 512'(0));
      check(tg({tag, "_rdata"}), 512'(dfp_rdata), 512'(0));
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int rdy_delay,
                           input int gap_lo, input int gap_hi);
      logic [LW-1:0] line;
      int r0, w0, b0;
      bit acc;
      if (!mem.exists(addr)) mem[addr] = rand_line();
      line = mem[addr];
      r0 = n_rresp; w0 = n_wresp; b0 = n_bread;
      dfp_addr = addr;
      dfp_read = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
        tick();
        bmem_resp  = 1'($urandom);
        bmem_rdata = junk();
        bmem_raddr = $urandom;
        if (bmem_read) begin
          if (n_bread - b0 == 1) check(tg("rd_addr"), 512'(bmem_addr), 512'(addr));
          bmem_ready = (n_bread - b0 > rdy_delay);
          acc = bmem_ready;
        end else bmem_ready = 1'b0;
      end
      check(tg("rd_accept"), 512'(acc), 512'(1));
      for (int b = 0; b < NB; b++) begin
        if (b > 0) begin
          repeat ($urandom_range(gap_hi, gap_lo)) begin
            tick();
            bmem_ready = 1'b0; bmem_resp = 1'b0; bmem_rdata = junk(); bmem_raddr = $urandom;
          end
        end
        tick();
        bmem_ready = 1'b0;
        bmem_resp  = 1'b1;
        bmem_rdata = line[b*BW +: BW];
        bmem_raddr = (b == 0) ? addr : AW'($urandom);
      end
      tick();
      bmem_resp = 1'b0;
      check(tg("rd_resp_pulse"), 512'(dfp_r_resp), 512'(1));
      check(tg("rd_line"), 512'(dfp_rdata), 512'(line));
      check(tg("rd_raddr"), 512'(dfp_raddr), 512'(addr));
      dfp_read = 1'b0;
      tick();
      check(tg("rd_resp_drop"), 512'(dfp_r_resp), 512'(0));
      check(tg("rd_line_hold"), 512'(dfp_rdata), 512'(line));
      check(tg("rd_pulses"), 512'({n_rresp - r0, n_wresp - w0}), 512'({32'd1, 32'd0}));
      check(tg("rd_req_cycles"), 512'(n_bread - b0), 512'(rdy_delay + 1));
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                            input logic [15:0] pat, input bit use_pat);
      int nacc, k, r0, w0;
      nacc = 0; k = 0; r0 = n_rresp; w0 = n_wresp;
      dfp_addr  = addr;
      dfp_wdata = line;
      dfp_write = 1'b1;
      for (int t = 0; t < 200 && nacc < NB; t++) begin
        tick();
        bmem_resp  = 1'($urandom);
        bmem_rdata = junk();
        if (bmem_write) begin
          if (k == 0) check(tg("wr_addr"), 512'(bmem_addr), 512'(addr));
          check(tg("wr_beat"), 512'(bmem_wdata), 512'(line[nacc*BW +: BW]));
          bmem_ready = use_pat ? ((k < 16) ? pat[k] : 1'b1) : 1'($urandom);
          k++;
          if (bmem_ready) nacc++;
        end else bmem_ready = 1'b0;
      end
      check(tg("wr_all_beats"), 512'(nacc), 512'(NB));
      tick();
      bmem_ready = 1'b0;
      bmem_resp  = 1'b0;
      check(tg("wr_resp_pulse"), 512'(dfp_w_resp), 512'(1));
      dfp_write = 1'b0;
      tick();
      check(tg("wr_resp_drop"), 512'(dfp_w_resp), 512'(0));
      check(tg("wr_pulses"), 512'({n_wresp - w0, n_rresp - r0}), 512'({32'd1, 32'd0}));
      mem[addr] = line;
    endtask

    task automatic reset_mid_read();
      logic [LW-1:0] line;
      int r0;
      line = rand_line();
      r0 = n_rresp;
      dfp_addr = 32'h0000_5000;
      dfp_read = 1'b1;
      tick();
      bmem_ready = 1'b1;
      tick();
      bmem_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
        bmem_resp  = 1'b1;
        bmem_rdata = line[b*BW +: BW];
        bmem_raddr = 32'h0000_5000;
        tick();
      end
      bmem_resp = 1'b0;
      dfp_read  = 1'b0;
      rst       = 1'b0;
      #1;
      check_outs_zero("rst_async");
      tick();
      rst = 1'b1;
      repeat (4) tick();
      check(tg("rst_no_pulse"), 512'(n_rresp - r0), 512'(0));
      check_outs_zero("rst_after");
    endtask

    initial begin
      logic [LW-1:0] line;
      n_rresp = 0; n_wresp = 0; n_bread = 0; n_both = 0;
      rst = 1'b0;
      dfp_read = 1'b0; dfp_write = 1'b0; dfp_addr = '0; dfp_wdata = '0;
      bmem_ready = 1'b0; bmem_resp = 1'b0; bmem_rdata = '0; bmem_raddr = '0;
      repeat (3) @(negedge clk);
      check_outs_zero("reset");
      rst = 1'b1;

      for (int b = 0; b < NB; b++) line[b*BW +: BW] = {(BW/8){8'(8'h11 * (b + 1))}};
      mem[32'h0000_1000] = line;
      do_read(32'h0000_1000, 0, 0, 0);
      do_read(32'h0000_1000 + LW / 8, 3, 2, 2);
      do_write(32'h0000_2000, rand_line(), 16'h002D, 1'b1);

      line      = rand_line();
      dfp_wdata = line;
      dfp_write = 1'b1;
      do_read(32'h0000_3000, 1, 0, 1);
      do_write(32'h0000_3000, line, 16'h0000, 1'b0);

      reset_mid_read();
      do_read(32'h0000_6000, 0, 0, 2);

      repeat (14) begin
        if ($urandom_range(1, 0) == 1) do_read(rand_addr(), $urandom_range(2, 0), 0, 2);
        else                           do_write(rand_addr(), rand_line(), 16'h0000, 1'b0);
      end
      check(tg("no_rd_wr_overlap"), 512'(n_both), 512'(0));
      done = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 40000; t++) begin
      @(posedge clk);
      if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
    end
    check("all_configs_done", 512'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done}), 512'(3'b111));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
